prog_run_ctrl: RTL and testbench

//  Sequencer upstream of the float2int core top. It preloads the core's data memory from a

---
 rtl/cpu_pkg.sv | 5 +
 rtl/prog_run_ctrl.sv | 81 ++++++++
 tb/tb_prog_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared run-sequencer state encoding and default run-cycle limit
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, TOUT} run_state_t;
  localparam int unsigned DEF_MAX_CYC = 32'hFFFF;
endpackage

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: preloads data_mem from a load stream, holds then releases core reset,
// and counts run cycles until the core reports done or the cycle limit is reached
module prog_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CW       = 16,
  parameter int unsigned MAX_CYC  = DEF_MAX_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  run_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_load, acc;
  assign in_load   = state_q == LOAD;
  assign acc       = in_load && ld_valid;
  assign ld_ready  = in_load;
  assign mem_we    = acc;
  assign mem_addr  = in_load ? ld_addr : '0;
  assign mem_wdata = in_load ? ld_data : '0;
  assign cpu_reset = state_q != RUN;
  assign busy      = in_load || state_q == HOLD || state_q == RUN;
  assign finished  = state_q == DONE;
  assign timeout   = state_q == TOUT;
  assign cycle_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt_q==1 marks the first RUN cycle, where done is still masked by the core's reset
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE, TOUT: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (acc && ld_last) begin
        state_d = HOLD;
        hold_d  = HW'(HOLD_CYC - 1);
      end
      HOLD: if (hold_q == '0) begin
        state_d = RUN;
        cnt_d   = CW'(1);
      end else hold_d = hold_q - HW'(1);
      RUN: if (cpu_done && cnt_q != CW'(1)) state_d = DONE;
        else if (cnt_q == CW'(MAX_CYC)) state_d = TOUT;
        else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb_prog_run_ctrl: scenario tasks for the load/hold/run sequencer; load writes are
// scoreboarded, with one instance at the default limit and one at MAX_CYC=20
module tb_prog_run_ctrl;
  logic clk = 0, reset = 1, start = 0, ld_valid = 0, ld_last = 0, cpu_done = 0;
  logic [7:0] ld_addr = 0, ld_data = 0;
  logic ld_ready, mem_we, cpu_reset, busy, finished, timeout;
  logic [7:0] mem_addr, mem_wdata;
  logic [15:0] cycle_cnt;
  logic ld_ready_b, mem_we_b, cpu_reset_b, busy_b, finished_b, timeout_b;
  logic [7:0] mem_addr_b, mem_wdata_b;
  logic [15:0] cycle_cnt_b;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  int tests = 0, fails = 0, wr_cnt = 0;

  prog_run_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .cpu_done(cpu_done),
    .busy(busy), .finished(finished), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  prog_run_ctrl #(.MAX_CYC(20)) u_dut20 (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .cpu_reset(cpu_reset_b),
    .cpu_done(cpu_done), .busy(busy_b), .finished(finished_b), .timeout(timeout_b),
    .cycle_cnt(cycle_cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (mem_we !== 1'b0) begin
    tests++;
    wr_cnt++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_write mem_we=%b addr=%h data=%h, no write expected", mem_we, mem_addr, mem_wdata);
    end else begin
      e = exp_q.pop_front();
      if ({mem_addr, mem_wdata} !== e) begin
        fails++;
        $display("FAIL write_data got addr=%h data=%h, expected addr=%h data=%h", mem_addr, mem_wdata, e[15:8], e[7:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1;
    cyc();
    start = 0;
    #1;
    tests++;
    if (ld_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL start_to_load ld_ready=%b busy=%b cpu_reset=%b, expected 1 1 1", ld_ready, busy, cpu_reset);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic last, input logic v);
    ld_valid = v;
    ld_addr = a;
    ld_data = d;
    ld_last = last;
    if (v) exp_q.push_back({a, d});
    #1;
    tests++;
    if (ld_ready !== 1'b1 || mem_we !== v) begin
      fails++;
      $display("FAIL load_handshake ld_ready=%b mem_we=%b, expected 1 %b", ld_ready, mem_we, v);
    end
    cyc();
    ld_valid = 0;
    ld_last = 0;
  endtask

  task automatic hold_and_release();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL writes_pending got %0d outstanding, expected 0", exp_q.size());
    end
    tests++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0 || cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL hold1 cpu_reset=%b busy=%b ld_ready=%b cnt=%0d, expected 1 1 0 0", cpu_reset, busy, ld_ready, cycle_cnt);
    end
    cyc();
    tests++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hold2 cpu_reset=%b busy=%b, expected 1 1", cpu_reset, busy);
    end
    cyc();
    tests++;
    if (cpu_reset !== 1'b0 || cycle_cnt !== 16'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL run_first cpu_reset=%b cnt=%0d busy=%b, expected 0 1 1", cpu_reset, cycle_cnt, busy);
    end
  endtask

  task automatic run_to(input int n);
    repeat (n - 1) cyc();
    tests++;
    if (cycle_cnt !== 16'(n) || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL run_count got cnt=%0d cpu_reset=%b, expected %0d 0", cycle_cnt, cpu_reset, n);
    end
  endtask

  task automatic finish_done(input int n);
    cpu_done = 1;
    cyc();
    cpu_done = 0;
    tests++;
    if (finished !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== 16'(n) || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done fin=%b tout=%b cnt=%0d cpu_reset=%b busy=%b, expected 1 0 %0d 1 0", finished, timeout, cycle_cnt, cpu_reset, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    #1;
    tests++;
    if (cpu_reset !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_mem cpu_reset=%b ld_ready=%b we=%b addr=%h data=%h, expected 1 0 0 00 00", cpu_reset, ld_ready, mem_we, mem_addr, mem_wdata);
    end
    tests++;
    if (busy !== 1'b0 || finished !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== 16'd0 || timeout_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_status busy=%b fin=%b tout=%b cnt=%0d tout_b=%b, expected 0 0 0 0 0", busy, finished, timeout, cycle_cnt, timeout_b);
    end
    cyc();
    tests++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL idle_stays busy=%b cpu_reset=%b, expected 0 1", busy, cpu_reset);
    end
  endtask

  task automatic test_load_run();
    int w0;
    do_start();
    w0 = wr_cnt;
    send(8'h00, 8'h3C, 0, 1);
    send(8'h01, 8'h00, 0, 1);
    send(8'h02, 8'h7F, 1, 1);
    tests++;
    if (wr_cnt - w0 != 3) begin
      fails++;
      $display("FAIL load3_writes got %0d, expected 3", wr_cnt - w0);
    end
    hold_and_release();
    run_to(37);
    finish_done(37);
    cyc();
    cyc();
    tests++;
    if (finished !== 1'b1 || cycle_cnt !== 16'd37 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL done_sticky fin=%b cnt=%0d cpu_reset=%b, expected 1 37 1", finished, cycle_cnt, cpu_reset);
    end
  endtask

  task automatic test_timeout();
    do_start();
    tests++;
    if (timeout_b !== 1'b0 || cycle_cnt_b !== 16'd0 || finished !== 1'b0 || cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL restart_clear tout_b=%b cnt_b=%0d fin=%b cnt=%0d, expected 0 0 0 0", timeout_b, cycle_cnt_b, finished, cycle_cnt);
    end
    send(8'h05, 8'h11, 1, 1);
    hold_and_release();
    run_to(20);
    cyc();
    tests++;
    if (timeout_b !== 1'b1 || finished_b !== 1'b0 || cycle_cnt_b !== 16'd20 || cpu_reset_b !== 1'b1 || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL timeout20 tout=%b fin=%b cnt=%0d cpu_reset=%b busy=%b, expected 1 0 20 1 0", timeout_b, finished_b, cycle_cnt_b, cpu_reset_b, busy_b);
    end
    tests++;
    if (cycle_cnt !== 16'd21 || busy !== 1'b1 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL default_limit_running cnt=%0d busy=%b tout=%b, expected 21 1 0", cycle_cnt, busy, timeout);
    end
    repeat (3) cyc();
    tests++;
    if (timeout_b !== 1'b1 || cycle_cnt_b !== 16'd20) begin
      fails++;
      $display("FAIL timeout_sticky tout=%b cnt=%0d, expected 1 20", timeout_b, cycle_cnt_b);
    end
    finish_done(24);
    do_start();
    send(8'h06, 8'h22, 1, 1);
    hold_and_release();
    run_to(20);
    cpu_done = 1;
    cyc();
    cpu_done = 0;
    tests++;
    if (finished_b !== 1'b1 || timeout_b !== 1'b0 || cycle_cnt_b !== 16'd20) begin
      fails++;
      $display("FAIL done_beats_timeout fin=%b tout=%b cnt=%0d, expected 1 0 20", finished_b, timeout_b, cycle_cnt_b);
    end
  endtask

  task automatic test_valid_gaps();
    int w0;
    do_start();
    w0 = wr_cnt;
    send(8'h10, 8'hAA, 0, 1);
    send(8'h11, 8'h55, 0, 0);
    send(8'h12, 8'h66, 1, 0);
    send(8'h13, 8'hBB, 1, 1);
    tests++;
    if (wr_cnt - w0 != 2) begin
      fails++;
      $display("FAIL gap_writes got %0d, expected 2", wr_cnt - w0);
    end
    hold_and_release();
    run_to(3);
    finish_done(3);
  endtask

  task automatic test_start_ignored_reset();
    do_start();
    send(8'h20, 8'h01, 1, 1);
    start = 1;
    #1;
    hold_and_release();
    start = 0;
    cyc();
    start = 1;
    cyc();
    start = 0;
    tests++;
    if (cycle_cnt !== 16'd3 || busy !== 1'b1 || cpu_reset !== 1'b0 || ld_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_in_run cnt=%0d busy=%b cpu_reset=%b ld_ready=%b, expected 3 1 0 0", cycle_cnt, busy, cpu_reset, ld_ready);
    end
    cyc();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    #1;
    tests++;
    if (busy !== 1'b0 || cycle_cnt !== 16'd0 || cpu_reset !== 1'b1 || finished !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_run busy=%b cnt=%0d cpu_reset=%b fin=%b tout=%b, expected 0 0 1 0 0", busy, cycle_cnt, cpu_reset, finished, timeout);
    end
    do_start();
    send(8'h21, 8'h02, 0, 1);
    send(8'h22, 8'h03, 1, 1);
    hold_and_release();
    run_to(4);
    finish_done(4);
  endtask

  task automatic test_back_to_back();
    do_start();
    tests++;
    if (finished !== 1'b0 || cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rerun_clear fin=%b cnt=%0d, expected 0 0", finished, cycle_cnt);
    end
    send(8'hFF, 8'hE7, 1, 1);
    hold_and_release();
    run_to(2);
    finish_done(2);
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_timeout();
    test_valid_gaps();
    test_start_ignored_reset();
    test_back_to_back();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
